// File: rtl/hart_lsu.sv
// hart_lsu: load/store unit on the hart data-memory port (issue, byte lanes, load extension).
// Define LSU_MISALIGNED_SPLIT_EN to split misaligned accesses into two aligned word accesses.
module hart_lsu (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_ren,
  output logic        o_dmem_wen,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_mask,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_trap
);

  typedef enum logic [0:0] {StIdle, StSplitHi} state_e;

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic        split_q, split_d;
  logic        trap_q, trap_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_addr_q, hi_addr_d;
  logic [3:0]  hi_mask_q, hi_mask_d;
  logic [31:0] hi_wdata_q, hi_wdata_d;

  logic [1:0]  off;
  logic [1:0]  size;
  logic        illegal;
  logic        misaligned;
  logic        trap;
  logic        split;
  logic        accept;
  logic [3:0]  size_mask;
  logic [31:0] wdata_sized;
  logic [7:0]  mask8;
  logic [63:0] wdata64;
  logic [63:0] rd64;
  logic [31:0] rsh;

  assign off  = i_req_addr[1:0];
  assign size = i_req_funct3[1:0];

  always_comb begin
    illegal = 1'b0;
    if (i_req_ren && i_req_wen) begin
      illegal = 1'b1;
    end else if (i_req_ren) begin
      illegal = (size == 2'b11) || (i_req_funct3[2] && (size == 2'b10));
    end else if (i_req_wen) begin
      illegal = i_req_funct3[2] || (size == 2'b11);
    end
  end

  assign misaligned = ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign trap  = illegal;
  assign split = !illegal && misaligned;
`else
  assign trap  = illegal || misaligned;
  assign split = 1'b0;
`endif

  assign accept = i_req_valid && (i_req_ren || i_req_wen);

  always_comb begin
    size_mask   = 4'b1111;
    wdata_sized = i_req_wdata;
    unique case (size)
      2'b00: begin
        size_mask   = 4'b0001;
        wdata_sized = {24'b0, i_req_wdata[7:0]};
      end
      2'b01: begin
        size_mask   = 4'b0011;
        wdata_sized = {16'b0, i_req_wdata[15:0]};
      end
      default: ;
    endcase
  end

  // Upper halves hold the bytes that spill into the next word on a split access.
  assign mask8   = {4'b0000, size_mask} << off;
  assign wdata64 = {32'b0, wdata_sized} << {off, 3'b000};

  always_comb begin
    state_d     = state_q;
    pend_d      = 1'b0;
    split_d     = 1'b0;
    trap_d      = trap_q;
    ren_d       = ren_q;
    wen_d       = wen_q;
    f3_d        = f3_q;
    off_d       = off_q;
    lo_d        = lo_q;
    hi_addr_d   = hi_addr_q;
    hi_mask_d   = hi_mask_q;
    hi_wdata_d  = hi_wdata_q;
    o_req_ready  = 1'b1;
    o_dmem_addr  = {i_req_addr[31:2], 2'b00};
    o_dmem_ren   = 1'b0;
    o_dmem_wen   = 1'b0;
    o_dmem_wdata = 32'b0;
    o_dmem_mask  = 4'b0000;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          trap_d     = trap;
          ren_d      = i_req_ren;
          wen_d      = i_req_wen;
          f3_d       = i_req_funct3;
          off_d      = off;
          hi_addr_d  = {i_req_addr[31:2], 2'b00} + 32'd4;
          hi_mask_d  = mask8[7:4];
          hi_wdata_d = wdata64[63:32];
          if (!trap) begin
            o_dmem_ren  = i_req_ren;
            o_dmem_wen  = i_req_wen;
            o_dmem_mask = mask8[3:0];
            if (i_req_wen) begin
              o_dmem_wdata = wdata64[31:0];
            end
          end
          if (split) begin
            state_d = StSplitHi;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      StSplitHi: begin
        o_req_ready = 1'b0;
        o_dmem_addr = hi_addr_q;
        o_dmem_ren  = ren_q;
        o_dmem_wen  = wen_q;
        o_dmem_mask = hi_mask_q;
        if (wen_q) begin
          o_dmem_wdata = hi_wdata_q;
        end
        lo_d    = i_dmem_rdata;
        pend_d  = 1'b1;
        split_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Split loads concatenate the captured low word under the high word before shifting.
  assign rd64 = split_q ? {i_dmem_rdata, lo_q} : {32'b0, i_dmem_rdata};
  assign rsh  = 32'(rd64 >> {off_q, 3'b000});

  always_comb begin
    o_rsp_valid = pend_q;
    o_rsp_trap  = pend_q && trap_q;
    o_rsp_rdata = 32'b0;
    if (pend_q && ren_q && !trap_q) begin
      unique case (f3_q)
        3'b000:  o_rsp_rdata = {{24{rsh[7]}}, rsh[7:0]};
        3'b001:  o_rsp_rdata = {{16{rsh[15]}}, rsh[15:0]};
        3'b100:  o_rsp_rdata = {24'b0, rsh[7:0]};
        3'b101:  o_rsp_rdata = {16'b0, rsh[15:0]};
        default: o_rsp_rdata = rsh;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      pend_q     <= 1'b0;
      split_q    <= 1'b0;
      trap_q     <= 1'b0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      lo_q       <= 32'b0;
      hi_addr_q  <= 32'b0;
      hi_mask_q  <= 4'b0000;
      hi_wdata_q <= 32'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      split_q    <= split_d;
      trap_q     <= trap_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      lo_q       <= lo_d;
      hi_addr_q  <= hi_addr_d;
      hi_mask_q  <= hi_mask_d;
      hi_wdata_q <= hi_wdata_d;
    end
  end

endmodule

// File: tb/tb_hart_lsu.sv
// tb_hart_lsu: directed and randomized self-checking bench for hart_lsu.
// Honours LSU_MISALIGNED_SPLIT_EN to select the expected misaligned behaviour.
module tb_hart_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_ren;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] dmem_addr;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mask;
  logic [31:0] dmem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_trap;

  int n_checks = 0;
  int n_fail   = 0;

  hart_lsu dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_ren    (req_ren),
    .i_req_wen    (req_wen),
    .i_req_funct3 (req_funct3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_dmem_addr  (dmem_addr),
    .o_dmem_ren   (dmem_ren),
    .o_dmem_wen   (dmem_wen),
    .o_dmem_wdata (dmem_wdata),
    .o_dmem_mask  (dmem_mask),
    .i_dmem_rdata (dmem_rdata),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_trap   (rsp_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: RV32I access rules in plain arithmetic.
  function automatic int acc_bytes(input logic [2:0] f3);
    return 1 << (int'(f3) % 4);
  endfunction

  function automatic logic model_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (int'(off) % acc_bytes(f3)) != 0;
  endfunction

  function automatic logic model_trap(input logic ren, input logic wen, input logic [2:0] f3,
                                      input logic [1:0] off);
    if (ren && wen) return 1'b1;
    if (ren && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (wen && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
`ifdef LSU_MISALIGNED_SPLIT_EN
    return 1'b0;
`else
    return model_misaligned(f3, off);
`endif
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [1:0] off);
    int m;
    m = ((1 << acc_bytes(f3)) - 1) << int'(off);
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] data);
    longint v;
    v = longint'(data) % (longint'(1) << (8 * acc_bytes(f3)));
    v = v * (longint'(1) << (8 * int'(off)));
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    longint v;
    longint span;
    v = longint'(rdata) / (longint'(1) << (8 * int'(off)));
    span = longint'(1) << (8 * acc_bytes(f3));
    v = v % span;
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  task automatic idle_inputs();
    req_valid  = 1'b0;
    req_ren    = 1'b0;
    req_wen    = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_checks++;
    if (rsp_trap !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_trap got %b want 0", rsp_trap); end
    n_checks++;
    if (dmem_ren !== 1'b0 || dmem_wen !== 1'b0) begin
      n_fail++; $display("FAIL reset_ren_wen got %b%b want 00", dmem_ren, dmem_wen);
    end
  endtask

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  mask;
    logic [31:0] dwdata;
    logic        trap;
    logic [31:0] rsp;
  } dir_t;

  task automatic test_directed();
    dir_t tbl [10];
    int   n;
    tbl[0] = '{1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 3'd0, 32'h13, 32'h000000A5, 32'h0, 4'b1000, 32'hA5000000, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 3'd0, 32'h13, 32'h0, 32'hA5000000, 4'b1000, 32'h0, 1'b0, 32'hFFFFFFA5};
    tbl[3] = '{1'b1, 1'b0, 3'd4, 32'h13, 32'h0, 32'hA5000000, 4'b1000, 32'h0, 1'b0, 32'h000000A5};
    tbl[4] = '{1'b1, 1'b0, 3'd1, 32'h12, 32'h0, 32'h80011234, 4'b1100, 32'h0, 1'b0, 32'hFFFF8001};
    tbl[5] = '{1'b1, 1'b0, 3'd5, 32'h10, 32'h0, 32'h80011234, 4'b0011, 32'h0, 1'b0, 32'h00001234};
    tbl[6] = '{1'b1, 1'b0, 3'd3, 32'h20, 32'h0, 32'h12345678, 4'b0000, 32'h0, 1'b1, 32'h0};
    tbl[7] = '{1'b1, 1'b1, 3'd2, 32'h24, 32'h5, 32'h12345678, 4'b0000, 32'h0, 1'b1, 32'h0};
    tbl[8] = '{1'b0, 1'b1, 3'd4, 32'h28, 32'h5, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0};
    tbl[9] = '{1'b1, 1'b0, 3'd2, 32'h11, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h0};
`ifdef LSU_MISALIGNED_SPLIT_EN
    n = 9;
`else
    n = 10;
`endif
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      req_valid  = 1'b1;
      req_ren    = tbl[i].ren;
      req_wen    = tbl[i].wen;
      req_funct3 = tbl[i].f3;
      req_addr   = tbl[i].addr;
      req_wdata  = tbl[i].wdata;
      @(negedge clk);
      n_checks++;
      if (dmem_ren !== (tbl[i].ren && !tbl[i].trap) || dmem_wen !== (tbl[i].wen && !tbl[i].trap)) begin
        n_fail++; $display("FAIL dir%0d_issue ren/wen got %b%b want %b%b", i, dmem_ren, dmem_wen,
                           tbl[i].ren && !tbl[i].trap, tbl[i].wen && !tbl[i].trap);
      end
      if (!tbl[i].trap) begin
        n_checks++;
        if (dmem_addr !== {tbl[i].addr[31:2], 2'b00} || dmem_mask !== tbl[i].mask) begin
          n_fail++; $display("FAIL dir%0d_addr_mask got %h/%b want %h/%b", i, dmem_addr, dmem_mask,
                             {tbl[i].addr[31:2], 2'b00}, tbl[i].mask);
        end
      end
      if (tbl[i].wen && !tbl[i].trap) begin
        n_checks++;
        if (dmem_wdata !== tbl[i].dwdata) begin
          n_fail++; $display("FAIL dir%0d_wdata got %h want %h", i, dmem_wdata, tbl[i].dwdata);
        end
      end
      @(posedge clk);
      #1;
      idle_inputs();
      dmem_rdata = tbl[i].rdata;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_trap !== tbl[i].trap || rsp_rdata !== tbl[i].rsp) begin
        n_fail++; $display("FAIL dir%0d_rsp got v%b t%b %h want v1 t%b %h", i, rsp_valid, rsp_trap,
                           rsp_rdata, tbl[i].trap, tbl[i].rsp);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_pulse got %b want 0", i, rsp_valid); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      idle_inputs();
      if (i < 3) begin
        req_valid  = 1'b1;
        req_ren    = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'(4 * i);
      end
      dmem_rdata = 32'hC0DE0000 + 32'(i);
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_ready got %b want 1", i, req_ready); end
      if (i < 3) begin
        n_checks++;
        if (dmem_ren !== 1'b1 || dmem_addr !== 32'(4 * i)) begin
          n_fail++; $display("FAIL b2b%0d_issue got %b %h want 1 %h", i, dmem_ren, dmem_addr, 4 * i);
        end
      end
      if (i > 0) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hC0DE0000 + 32'(i)) begin
          n_fail++; $display("FAIL b2b%0d_rsp got %b %h want 1 %h", i, rsp_valid, rsp_rdata,
                             32'hC0DE0000 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_random();
    logic        p_valid = 1'b0;
    logic        p_ren   = 1'b0;
    logic        p_trap  = 1'b0;
    logic [2:0]  p_f3    = 3'd0;
    logic [1:0]  p_off   = 2'd0;
    logic        t;
    logic        acc;
    logic [31:0] exp_rd;
    int          kind;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      dmem_rdata = $urandom;
      kind       = $urandom_range(0, 9);
      req_valid  = ($urandom_range(0, 3) != 0);
      req_ren    = (kind < 5) || (kind == 9 && $urandom_range(0, 1) == 1);
      req_wen    = (kind >= 5 && kind < 9) || (kind == 9 && $urandom_range(0, 1) == 1);
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr   = $urandom;
      req_wdata  = $urandom;
`ifdef LSU_MISALIGNED_SPLIT_EN
      if (model_misaligned(req_funct3, req_addr[1:0])) req_addr[1:0] = 2'b00;
`endif
      t   = model_trap(req_ren, req_wen, req_funct3, req_addr[1:0]);
      acc = req_valid && (req_ren || req_wen);
      exp_rd = (p_ren && !p_trap) ? model_load(p_f3, p_off, dmem_rdata) : 32'h0;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_ready got %b want 1", c, req_ready); end
      n_checks++;
      if (rsp_valid !== p_valid || rsp_trap !== (p_valid && p_trap)) begin
        n_fail++; $display("FAIL rnd%0d_rsp_flags got v%b t%b want v%b t%b", c, rsp_valid, rsp_trap,
                           p_valid, p_valid && p_trap);
      end
      if (p_valid) begin
        n_checks++;
        if (rsp_rdata !== exp_rd) begin
          n_fail++; $display("FAIL rnd%0d_rsp_rdata got %h want %h", c, rsp_rdata, exp_rd);
        end
      end
      n_checks++;
      if (dmem_ren !== (acc && req_ren && !t) || dmem_wen !== (acc && req_wen && !t)) begin
        n_fail++; $display("FAIL rnd%0d_ren_wen got %b%b want %b%b", c, dmem_ren, dmem_wen,
                           acc && req_ren && !t, acc && req_wen && !t);
      end
      if (acc && !t) begin
        n_checks++;
        if (dmem_addr !== {req_addr[31:2], 2'b00} ||
            dmem_mask !== model_mask(req_funct3, req_addr[1:0])) begin
          n_fail++; $display("FAIL rnd%0d_addr_mask got %h/%b want %h/%b", c, dmem_addr, dmem_mask,
                             {req_addr[31:2], 2'b00}, model_mask(req_funct3, req_addr[1:0]));
        end
        if (req_wen) begin
          n_checks++;
          if (dmem_wdata !== model_wdata(req_funct3, req_addr[1:0], req_wdata)) begin
            n_fail++; $display("FAIL rnd%0d_wdata got %h want %h", c, dmem_wdata,
                               model_wdata(req_funct3, req_addr[1:0], req_wdata));
          end
        end
      end
      p_valid = acc;
      p_ren   = req_ren;
      p_trap  = t;
      p_f3    = req_funct3;
      p_off   = req_addr[1:0];
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

`ifdef LSU_MISALIGNED_SPLIT_EN
  task automatic test_split();
    // Split load across 0x10/0x14, then a split store wrapping past the top of memory.
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_ren = 1'b1; req_wen = 1'b0; req_funct3 = 3'd2; req_addr = 32'h11;
    @(negedge clk);
    n_checks++;
    if (dmem_ren !== 1'b1 || dmem_addr !== 32'h10 || dmem_mask !== 4'b1110) begin
      n_fail++; $display("FAIL split_lo got %b %h %b want 1 00000010 1110", dmem_ren, dmem_addr, dmem_mask);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    dmem_rdata = 32'h332211EE;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || dmem_ren !== 1'b1 || dmem_addr !== 32'h14 || dmem_mask !== 4'b0001 ||
        rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL split_hi got r%b %b %h %b v%b want r0 1 00000014 0001 v0", req_ready,
                         dmem_ren, dmem_addr, dmem_mask, rsp_valid);
    end
    @(posedge clk);
    #1;
    dmem_rdata = 32'hCCBBAA44;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_trap !== 1'b0 || rsp_rdata !== 32'h44332211 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL split_rsp got v%b t%b %h r%b want v1 t0 44332211 r1", rsp_valid, rsp_trap,
                         rsp_rdata, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'd2; req_addr = 32'hFFFFFFFF;
    req_wdata = 32'h11223344;
    @(negedge clk);
    n_checks++;
    if (dmem_wen !== 1'b1 || dmem_mask !== 4'b1000 || dmem_wdata[31:24] !== 8'h44) begin
      n_fail++; $display("FAIL split_st_lo got %b %b %h want 1 1000 44xxxxxx", dmem_wen, dmem_mask, dmem_wdata);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (dmem_wen !== 1'b1 || dmem_addr !== 32'h0 || dmem_mask !== 4'b0111 ||
        dmem_wdata[23:0] !== 24'h112233) begin
      n_fail++; $display("FAIL split_st_hi got %b %h %b %h want 1 00000000 0111 xx112233", dmem_wen,
                         dmem_addr, dmem_mask, dmem_wdata);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_trap !== 1'b0) begin
      n_fail++; $display("FAIL split_st_rsp got v%b t%b %h want v1 t0 0", rsp_valid, rsp_trap, rsp_rdata);
    end
  endtask
`endif

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_ren = 1'b1; req_wen = 1'b0; req_funct3 = 3'd2;
`ifdef LSU_MISALIGNED_SPLIT_EN
    req_addr = 32'h42;
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b1;
`else
    req_addr = 32'h40;
    rst = 1'b1;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    dmem_rdata = 32'h87654321;
    @(negedge clk);
    n_checks++;
    if (dmem_ren !== 1'b0 || dmem_wen !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid got ren%b wen%b v%b r%b want 0 0 0 1", dmem_ren, dmem_wen,
                         rsp_valid, req_ready);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_late got v%b want 0", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
`ifdef LSU_MISALIGNED_SPLIT_EN
    test_split();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
